pipeline_ctrl_fsm: RTL

- Sequencing controller for the 5-stage pipeline: decides each cycle whether PC, IF/ID and the downstream stages advance.
- Generates the bubble select for the control-signal mux at ID/EX. `o_ctrl_selector`=0 zeroes all control fields.
- Supports continuous run, single-step (debug unit) and HALT drain.
- Detects load-use hazards and taken-branch flushes.

---
 rtl/pipeline_ctrl_fsm.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl_fsm.sv
// Pipeline sequencing controller: run/step/HALT-drain control with load-use stall and branch flush.
// Optional macro STALL_COUNTER_EN enables the saturating load-use bubble counter on o_stall_count.
module pipeline_ctrl_fsm #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 16,
  parameter int REG_W        = 5
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_mode_run,
  input  logic             i_step,
  input  logic             i_halt_instr,
  input  logic             i_branch_taken,
  input  logic             i_id_ex_memread,
  input  logic [REG_W-1:0] i_id_ex_rt,
  input  logic [REG_W-1:0] i_if_id_rs,
  input  logic [REG_W-1:0] i_if_id_rt,
  output logic             o_pc_enable,
  output logic             o_if_id_enable,
  output logic             o_if_id_flush,
  output logic             o_ctrl_selector,
  output logic             o_pipe_enable,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_stall_count
);

  // state  | meaning
  // IDLE   | pipeline frozen, waiting for run mode or a step edge
  // RUN    | continuous execution
  // STEP   | one active cycle requested by the debug unit
  // DRAIN  | HALT seen in ID; older instructions retire, bubbles behind
  // HALTED | frozen until reset
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RUN    = 3'd1;
  localparam logic [2:0] STEP   = 3'd2;
  localparam logic [2:0] DRAIN  = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  logic [2:0]       state, stateNext;
  logic [CNT_W-1:0] drainCnt, drainCntNext;
  logic             stepQ;
  logic             stepEdge;
  logic             active;
  logic             loadUse;

  assign stepEdge = i_step && !stepQ;
  assign active   = (state == RUN) || (state == STEP);
  assign loadUse  = i_id_ex_memread && (i_id_ex_rt != '0) &&
                    ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      drainCnt <= '0;
      stepQ    <= 1'b0;
    end else begin
      state    <= stateNext;
      drainCnt <= drainCntNext;
      stepQ    <= i_step;
    end
  end

  // HALT only takes effect in a cycle that is not stalled by load-use.
  always_comb begin
    stateNext    = state;
    drainCntNext = drainCnt;
    case (state)
      IDLE: begin
        if (i_mode_run)    stateNext = RUN;
        else if (stepEdge) stateNext = STEP;
      end
      RUN, STEP: begin
        if (!loadUse && i_halt_instr) begin
          stateNext    = DRAIN;
          drainCntNext = CNT_W'(DRAIN_CYCLES - 1);
        end else if (state == STEP || !i_mode_run) begin
          stateNext = IDLE;
        end
      end
      DRAIN: begin
        if (drainCnt == '0) stateNext = HALTED;
        else                drainCntNext = drainCnt - CNT_W'(1);
      end
      HALTED:  stateNext = HALTED;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    o_pc_enable     = 1'b0;
    o_if_id_enable  = 1'b0;
    o_if_id_flush   = 1'b0;
    o_ctrl_selector = 1'b0;
    o_pipe_enable   = 1'b0;
    o_halted        = 1'b0;
    case (state)
      RUN, STEP: begin
        o_pipe_enable = 1'b1;
        if (!loadUse) begin
          o_pc_enable     = 1'b1;
          o_if_id_enable  = 1'b1;
          o_ctrl_selector = 1'b1;
          o_if_id_flush   = i_branch_taken && !i_halt_instr;
        end
      end
      DRAIN:   o_pipe_enable = 1'b1;
      HALTED:  o_halted = 1'b1;
      default: ;
    endcase
  end

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stallCnt;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                                 stallCnt <= '0;
    else if (active && loadUse && stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
  end

  assign o_stall_count = stallCnt;
`else
  assign o_stall_count = '0;
`endif

endmodule
